// File: rtl/dmem_sram.sv
// Word-organised data SRAM slave: byte-strobe writes, one-cycle registered reads,
// out-of-range read error response and optional LFSR-driven back-pressure.
module dmem_sram #(
    parameter int          DEPTH_LOG2 = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          STALL_EN   = 1'b0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        dmem_wready,
    output logic        dmem_wvalid,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    input  logic        dmem_rready,
    output logic        dmem_rvalid,
    input  logic [31:0] dmem_raddr,
    output logic        dmem_rresp,
    output logic [31:0] dmem_rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_next;
    logic [31:0]           woff;
    logic [31:0]           roff;
    logic                  w_in_range;
    logic                  r_in_range;
    logic                  w_fire;
    logic                  r_fire;
    logic [DEPTH_LOG2-1:0] widx;
    logic [DEPTH_LOG2-1:0] ridx;

    // Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0
    always_comb begin
        lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Range is judged on the full 32-bit offset; only the index bits address the array
    assign woff       = dmem_waddr - BASE_ADDR;
    assign roff       = dmem_raddr - BASE_ADDR;
    assign w_in_range = (woff >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign r_in_range = (roff >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign widx       = dmem_waddr[DEPTH_LOG2+1:2];
    assign ridx       = dmem_raddr[DEPTH_LOG2+1:2];
    assign w_fire     = dmem_wready && dmem_wvalid;
    assign r_fire     = dmem_rready && dmem_rvalid;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lfsr        <= LFSR_SEED;
            dmem_wvalid <= 1'b0;
            dmem_rvalid <= 1'b0;
        end else begin
            lfsr        <= lfsr_next;
            dmem_wvalid <= STALL_EN ? (lfsr_next[1:0] != 2'b00) : 1'b1;
            dmem_rvalid <= STALL_EN ? (lfsr_next[3:2] != 2'b00) : 1'b1;
        end
    end

    // Array is deliberately not reset so its contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (w_fire && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wstrb[i]) begin
                    mem[widx][8*i +: 8] <= dmem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Sampling the array in the same edge as the write gives read-before-write
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dmem_rresp <= 1'b0;
            dmem_rdata <= 32'h0;
        end else if (r_fire) begin
            dmem_rresp <= r_in_range;
            dmem_rdata <= r_in_range ? mem[ridx] : 32'h0;
        end
    end

endmodule

// File: tb/tb_dmem_sram.sv
// Self-checking bench for dmem_sram: a table-driven run on a no-stall instance,
// randomised held-request traffic on a stalling instance, and a reset sequence.
module tb_dmem_sram;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    logic        a_wready, a_wvalid, a_rready, a_rvalid, a_rresp;
    logic [31:0] a_waddr, a_wdata, a_raddr, a_rdata;
    logic [3:0]  a_wstrb;
    logic        b_wready, b_wvalid, b_rready, b_rvalid, b_rresp;
    logic [31:0] b_waddr, b_wdata, b_raddr, b_rdata;
    logic [3:0]  b_wstrb;

    dmem_sram #(.STALL_EN(1'b0)) dut_a (
        .clk(clk), .resetb(resetb),
        .dmem_wready(a_wready), .dmem_wvalid(a_wvalid), .dmem_waddr(a_waddr),
        .dmem_wdata(a_wdata), .dmem_wstrb(a_wstrb),
        .dmem_rready(a_rready), .dmem_rvalid(a_rvalid), .dmem_raddr(a_raddr),
        .dmem_rresp(a_rresp), .dmem_rdata(a_rdata)
    );

    dmem_sram #(.STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .resetb(resetb),
        .dmem_wready(b_wready), .dmem_wvalid(b_wvalid), .dmem_waddr(b_waddr),
        .dmem_wdata(b_wdata), .dmem_wstrb(b_wstrb),
        .dmem_rready(b_rready), .dmem_rvalid(b_rvalid), .dmem_raddr(b_raddr),
        .dmem_rresp(b_rresp), .dmem_rdata(b_rdata)
    );

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        rd;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic        exp_rresp;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        rresp;
        int          tag;
    } exp_t;

    localparam int NV = 20;
    localparam int NTX = 1000;

    vec_t        vecs [NV];
    exp_t        sbq [$];
    exp_t        e;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model [64];

    int b_wvalid_hi = 0, b_wacc = 0, b_rvalid_hi = 0, b_racc = 0;
    bit count_w = 1'b0, count_r = 1'b0;

    always @(posedge clk) begin
        if (count_w) begin
            if (b_wvalid) b_wvalid_hi++;
            if (b_wvalid && b_wready) b_wacc++;
        end
        if (count_r) begin
            if (b_rvalid) b_rvalid_hi++;
            if (b_rvalid && b_rready) b_racc++;
        end
    end

    // Core-side obligation: an un-accepted request stays asserted and stable
    logic        w_pend = 1'b0, r_pend = 1'b0;
    logic [67:0] w_held;
    logic [31:0] r_held;
    always @(posedge clk) begin
        if (resetb) begin
            if (w_pend) assert (b_wready && {b_waddr, b_wdata, b_wstrb} == w_held)
                else $error("[TB] write request changed while pending");
            if (r_pend) assert (b_rready && b_raddr == r_held)
                else $error("[TB] read request changed while pending");
        end
        w_pend <= resetb && b_wready && !b_wvalid;
        r_pend <= resetb && b_rready && !b_rvalid;
        w_held <= {b_waddr, b_wdata, b_wstrb};
        r_held <= b_raddr;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        a_wready = v.wr;
        a_waddr  = v.waddr;
        a_wdata  = v.wdata;
        a_wstrb  = v.wstrb;
        a_rready = v.rd;
        a_raddr  = v.raddr;
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic vec_t mk(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                                input logic [3:0] ws, input logic rd, input logic [31:0] ra,
                                input logic [31:0] er, input logic ep);
        vec_t v;
        v.wr = wr; v.waddr = wa; v.wdata = wd; v.wstrb = ws;
        v.rd = rd; v.raddr = ra; v.exp_rdata = er; v.exp_rresp = ep;
        return v;
    endfunction

    vec_t idle_v;

    initial begin
        int          done, cyc, idx, tag;
        bit          pending;
        logic [15:0] m;
        logic [31:0] cur_addr, cur_data;
        logic [3:0]  cur_strb;

        // Expected outputs are those seen in the cycle after each vector is applied
        vecs[0]  = mk(1, 32'h100,   32'hDEADBEEF, 4'hF, 0, 32'h0,       32'h0,        0);
        vecs[1]  = mk(0, 32'h0,     32'h0,        4'h0, 1, 32'h100,     32'hDEADBEEF, 1);
        vecs[2]  = mk(1, 32'h100,   32'h0000AB00, 4'b0010, 0, 32'h0,    32'hDEADBEEF, 1);
        vecs[3]  = mk(0, 32'h0,     32'h0,        4'h0, 1, 32'h100,     32'hDEADABEF, 1);
        vecs[4]  = mk(0, 32'h0,     32'h0,        4'h0, 1, 32'h102,     32'hDEADABEF, 1);
        vecs[5]  = mk(1, 32'h100,   32'h12345678, 4'hF, 1, 32'h100,     32'hDEADABEF, 1);
        vecs[6]  = mk(0, 32'h0,     32'h0,        4'h0, 1, 32'h100,     32'h12345678, 1);
        vecs[7]  = mk(1, 32'h0,     32'hCAFEF00D, 4'hF, 0, 32'h0,       32'h12345678, 1);
        vecs[8]  = mk(0, 32'h0,     32'h0,        4'h0, 1, 32'h40000,   32'h0,        0);
        vecs[9]  = mk(1, 32'h40000, 32'h11111111, 4'hF, 0, 32'h0,       32'h0,        0);
        vecs[10] = mk(0, 32'h0,     32'h0,        4'h0, 0, 32'h0,       32'h0,        0);
        vecs[11] = mk(0, 32'h0,     32'h0,        4'h0, 1, 32'h0,       32'hCAFEF00D, 1);
        vecs[12] = mk(1, 32'h104,   32'h01020304, 4'hF, 0, 32'h0,       32'hCAFEF00D, 1);
        vecs[13] = mk(1, 32'h104,   32'hFFFFFFFF, 4'h0, 0, 32'h0,       32'hCAFEF00D, 1);
        vecs[14] = mk(0, 32'h0,     32'h0,        4'h0, 1, 32'h104,     32'h01020304, 1);
        vecs[15] = mk(1, 32'h104,   32'hAABBCCDD, 4'b1001, 0, 32'h0,    32'h01020304, 1);
        vecs[16] = mk(0, 32'h0,     32'h0,        4'h0, 1, 32'h104,     32'hAA0203DD, 1);
        vecs[17] = mk(1, 32'h3FFFC, 32'h5A5A5A5A, 4'hF, 0, 32'h0,       32'hAA0203DD, 1);
        vecs[18] = mk(0, 32'h0,     32'h0,        4'h0, 1, 32'h3FFFC,   32'h5A5A5A5A, 1);
        vecs[19] = mk(0, 32'h0,     32'h0,        4'h0, 1, 32'hFFFFFFFC, 32'h0,       0);
        idle_v   = mk(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 32'h0, 0);

        applyStimulus(idle_v);
        b_wready = 0; b_waddr = 0; b_wdata = 0; b_wstrb = 0; b_rready = 0; b_raddr = 0;

        #1;
        checkOutput("reset_a_wvalid", a_wvalid, 0);
        checkOutput("reset_a_rvalid", a_rvalid, 0);
        checkOutput("reset_a_rresp",  a_rresp,  0);
        checkOutput("reset_a_rdata",  a_rdata,  0);
        checkOutput("reset_b_wvalid", b_wvalid, 0);
        checkOutput("reset_b_rvalid", b_rvalid, 0);
        repeat (3) @(negedge clk);
        resetb = 1'b1;

        // First 16 post-reset valids of the stalling instance against a golden LFSR
        m = 16'hACE1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            m = lfsrStep(m);
            checkOutput($sformatf("lfsr_wvalid_%0d", k), b_wvalid, m[1:0] != 2'b00);
            checkOutput($sformatf("lfsr_rvalid_%0d", k), b_rvalid, m[3:2] != 2'b00);
            if (k < 2) begin
                checkOutput($sformatf("nostall_wvalid_%0d", k), a_wvalid, 1);
                checkOutput($sformatf("nostall_rvalid_%0d", k), a_rvalid, 1);
            end
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput($sformatf("vec%0d_rdata", e.tag), a_rdata, e.rdata);
                checkOutput($sformatf("vec%0d_rresp", e.tag), a_rresp, e.rresp);
            end
            applyStimulus(vecs[i]);
            sbq.push_back('{vecs[i].exp_rdata, vecs[i].exp_rresp, i});
        end
        @(negedge clk);
        applyStimulus(idle_v);
        e = sbq.pop_front();
        checkOutput($sformatf("vec%0d_rdata", e.tag), a_rdata, e.rdata);
        checkOutput($sformatf("vec%0d_rresp", e.tag), a_rresp, e.rresp);

        // Stalling instance: held random writes; first 64 fill every tracked word
        done = 0; cyc = 0; pending = 0;
        @(negedge clk);
        cur_addr = 0; cur_data = $urandom; cur_strb = 4'hF;
        b_wready = 1; b_waddr = cur_addr; b_wdata = cur_data; b_wstrb = cur_strb;
        count_w = 1;
        pending = b_wvalid;
        while (done < NTX && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                idx = int'(cur_addr[7:2]);
                for (int l = 0; l < 4; l++)
                    if (cur_strb[l]) model[idx][8*l +: 8] = cur_data[8*l +: 8];
                done++;
                if (done < NTX) begin
                    idx      = (done < 64) ? done : int'($urandom_range(0, 63));
                    cur_addr = (idx * 4) | $urandom_range(0, 3);
                    cur_data = $urandom;
                    cur_strb = (done < 64) ? 4'hF : 4'($urandom_range(0, 15));
                    b_waddr = cur_addr; b_wdata = cur_data; b_wstrb = cur_strb;
                end else begin
                    count_w  = 0;
                    b_wready = 0;
                end
            end
            pending = b_wready && b_wvalid;
        end
        if (done < NTX) $display("[TB] FAIL write_phase_timeout: got %0d writes, expected %0d", done, NTX);
        count_w = 0; b_wready = 0;
        checkOutput("stall_write_accepts", b_wacc, NTX);
        checkOutput("stall_write_valid_cycles", b_wvalid_hi, NTX);

        // Held random reads, roughly one in eight out of range
        done = 0; cyc = 0; pending = 0;
        sbq.delete();
        @(negedge clk);
        cur_addr = $urandom_range(0, 255);
        b_rready = 1; b_raddr = cur_addr;
        count_r = 1;
        tag = 0;
        if (b_rvalid) begin
            sbq.push_back('{model[cur_addr[7:2]], 1'b1, tag});
            pending = 1;
        end
        while (done < NTX && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                e = sbq.pop_front();
                checkOutput($sformatf("stall_rd%0d_rdata", e.tag), b_rdata, e.rdata);
                checkOutput($sformatf("stall_rd%0d_rresp", e.tag), b_rresp, e.rresp);
                done++;
                tag++;
                if (done < NTX) begin
                    if ($urandom_range(0, 7) == 0)
                        cur_addr = 32'h0004_0000 + ($urandom_range(0, 63) * 4)
                                   + ($urandom_range(0, 1) ? 32'hFFF0_0000 : 32'h0);
                    else
                        cur_addr = $urandom_range(0, 255);
                    b_raddr = cur_addr;
                end else begin
                    count_r  = 0;
                    b_rready = 0;
                end
            end
            pending = b_rready && b_rvalid;
            if (pending) begin
                if (cur_addr < 32'h0004_0000) sbq.push_back('{model[cur_addr[7:2]], 1'b1, tag});
                else sbq.push_back('{32'h0, 1'b0, tag});
            end
        end
        if (done < NTX) $display("[TB] FAIL read_phase_timeout: got %0d reads, expected %0d", done, NTX);
        count_r = 0; b_rready = 0;
        checkOutput("stall_read_accepts", b_racc, NTX);
        checkOutput("stall_read_valid_cycles", b_rvalid_hi, NTX);

        // Reset right after a read is accepted clears results but not the array
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0, 1, 32'h100, 0, 0));
        @(negedge clk);
        checkOutput("pre_reset_rdata", a_rdata, 32'h12345678);
        applyStimulus(mk(0, 0, 0, 0, 1, 32'h0, 0, 0));
        @(posedge clk);
        #1;
        resetb = 1'b0;
        #1;
        checkOutput("midreset_a_wvalid", a_wvalid, 0);
        checkOutput("midreset_a_rvalid", a_rvalid, 0);
        checkOutput("midreset_a_rresp",  a_rresp,  0);
        checkOutput("midreset_a_rdata",  a_rdata,  0);
        checkOutput("midreset_b_rvalid", b_rvalid, 0);
        applyStimulus(mk(1, 32'h100, 32'h0, 4'hF, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        applyStimulus(idle_v);
        resetb = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_wvalid", a_wvalid, 1);
        checkOutput("post_reset_rresp",  a_rresp,  0);
        applyStimulus(mk(0, 0, 0, 0, 1, 32'h100, 0, 0));
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0, 1, 32'h0, 0, 0));
        checkOutput("post_reset_rd100_rdata", a_rdata, 32'h12345678);
        checkOutput("post_reset_rd100_rresp", a_rresp, 1);
        @(negedge clk);
        applyStimulus(idle_v);
        checkOutput("post_reset_rd0_rdata", a_rdata, 32'hCAFEF00D);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_sram.md
Name: dmem_sram

Overview:
- Data-memory slave for the core's dmem write and read channels. It terminates every non-MMIO data access that the top level forwards outward.
- Provides a word-organised synchronous SRAM with byte-strobe writes, one-cycle registered read data, and out-of-range error response.
- An optional LFSR-driven back-pressure generator stresses the core's handshake in simulation.
- Instantiated beside the top level and wired port-for-port to its dmem_* interface.

Parameters:
- DEPTH_LOG2, 16: log2 of memory depth in 32-bit words (default 256 KiB).
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be aligned to 4<<DEPTH_LOG2.
- STALL_EN, 0: 1 enables pseudo-random de-assertion of wvalid/rvalid.
- LFSR_SEED, 16'hACE1: reset value of the stall LFSR. Must be non-zero.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- dmem_wready  in  1  write request from core; address, data and strobe are valid while high
- dmem_wvalid  out  1  slave can accept a write this cycle
- dmem_waddr  in  32  write byte address
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte enables; bit n covers wdata[8n+7:8n]
- dmem_rready  in  1  read request from core
- dmem_rvalid  out  1  slave can accept a read this cycle
- dmem_raddr  in  32  read byte address
- dmem_rresp  out  1  read response for the last accepted read: 1 = OK, 0 = address error
- dmem_rdata  out  32  read data for the last accepted read

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-low.
- Reset values: dmem_wvalid=0, dmem_rvalid=0, dmem_rresp=0, dmem_rdata=0, LFSR=LFSR_SEED.
  - Memory array contents are not reset and survive a reset pulse.
- Word index: addr[DEPTH_LOG2+1:2]; addr[1:0] is ignored.
- Range check: an address is in range iff (addr - BASE_ADDR) >> 2 < 2^DEPTH_LOG2, computed as a 32-bit unsigned subtraction.
- Write handshake: a write is accepted at a rising edge where dmem_wready && dmem_wvalid.
  - Each byte lane with wstrb[n]=1 is updated at that edge; lanes with wstrb[n]=0 are unchanged.
  - wstrb=4'b0000 is accepted and writes nothing.
  - An out-of-range write is accepted (wvalid behaves normally) and silently dropped; there is no error signal on the write channel.
- Read handshake: a read is accepted at a rising edge where dmem_rready && dmem_rvalid.
  - dmem_rdata and dmem_rresp update at that same edge, so they are valid in the cycle after acceptance. This is a fixed latency of 1, which the top level's registered data_sel depends on.
  - Out-of-range read: rresp=0, rdata=32'h0. In-range read: rresp=1, rdata=array word.
- Hold rule: rdata and rresp hold their value until the next accepted read. Cycles without an accepted read do not change them.
- Simultaneous read and write:
  - Both channels are independent; both may be accepted in the same cycle.
  - Same word index: read-before-write, i.e. rdata returns the pre-write contents.
  - The write is visible to any read accepted on a later edge.
- Back-pressure, STALL_EN=0: wvalid and rvalid go to 1 on the first clock after reset release and stay at 1.
- Back-pressure, STALL_EN=1:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; shifts left, feedback into bit 0) advances every cycle after reset.
  - Registered wvalid <= (lfsr_next[1:0] != 2'b00); registered rvalid <= (lfsr_next[3:2] != 2'b00), giving about 25% stall per channel.
  - The valids never depend combinationally on wready/rready.
- Core obligation (checked by bench assertion, not by RTL): while a request is pending and not yet accepted, the core holds ready and its address/data/strb stable. The slave does not latch an un-accepted request.
- Reset mid-operation: any accepted-but-not-yet-consumed read result is discarded (rdata/rresp forced to 0). An accepted write completes only if its edge occurred before resetb fell.
- X handling: with DEPTH_LOG2 < 30, address bits above the index take part only in the range check.

Test Plan:
- STALL_EN=0: write 0x100 = 32'hDEADBEEF with strb 4'hF, then read 0x100 -> next cycle rdata=32'hDEADBEEF, rresp=1.
- Write 0x100 with wdata 32'h0000AB00, strb 4'b0010, then read -> rdata=32'hDEADABEF. Read 0x102 -> same word (low bits ignored).
- Same cycle: write 0x100 = 32'h12345678 (strb 4'hF) and read 0x100 -> rdata=32'hDEADABEF. A read on the following cycle -> 32'h12345678.
- DEPTH_LOG2=16, BASE_ADDR=0: read 0x0004_0000 -> rresp=0, rdata=0. Write 0x0004_0000 then read 0x0 -> word 0 unchanged. Idle cycles afterwards hold rresp=0.
- STALL_EN=1: issue 1000 back-to-back random writes then reads with the held-request rule.
  - All read data match a scoreboard.
  - Accept counts equal the count of cycles where the valid was high.
  - The first 16 wvalid values match a golden LFSR model seeded 16'hACE1.
- Assert resetb low one cycle after a read is accepted -> rvalid, wvalid, rresp and rdata read 0 immediately. After release, a read of a previously written word returns that data unchanged.
